// File: rtl/divmod_arbiter_if.sv
// Bundle between the requester lanes, the round-robin arbiter and a shared divmod unit.
// The arbiter takes the master view; the environment (lanes plus divider) takes the slave view.
interface divmod_arbiter_if #(
    parameter int WIDTH_LOG = 4,
    parameter int NREQ      = 4
);
    localparam int WIDTH = 1 << WIDTH_LOG;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      res_rem;
    logic [WIDTH-1:0]      res_quot;
    logic                  res_error;
    logic                  div_go;
    logic [WIDTH-1:0]      div_a;
    logic [WIDTH-1:0]      div_b;
    logic                  div_ready;
    logic                  div_error;
    logic [WIDTH-1:0]      div_rem;
    logic [WIDTH-1:0]      div_quot;

    modport master (
        input  req, req_a, req_b, div_ready, div_error, div_rem, div_quot,
        output gnt, done, res_rem, res_quot, res_error, div_go, div_a, div_b
    );

    modport slave (
        output req, req_a, req_b, div_ready, div_error, div_rem, div_quot,
        input  gnt, done, res_rem, res_quot, res_error, div_go, div_a, div_b
    );
endinterface

// File: rtl/divmod_arbiter.sv
// Round-robin arbiter time-sharing one divmod unit between NREQ lanes.
// Each grant runs IDLE -> ISSUE -> WAIT -> DONE and returns the result with a one-cycle done pulse.
module divmod_arbiter #(
    parameter int WIDTH_LOG = 4,
    parameter int NREQ      = 4,
    parameter int NREQ_LOG  = 2
) (
    input  logic             clk,
    input  logic             rst,
    divmod_arbiter_if.master bus
);
    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int PW    = NREQ_LOG + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state;
    logic [NREQ_LOG-1:0] ptr;
    logic [NREQ_LOG-1:0] gnt_idx;
    logic [NREQ-1:0]     gnt_q;
    logic [NREQ-1:0]     done_q;
    logic                go_q;
    logic [WIDTH-1:0]    rem_q;
    logic [WIDTH-1:0]    quot_q;
    logic                error_q;

    logic [2*NREQ-1:0]   req_dbl;
    logic [NREQ-1:0]     req_rot;
    logic [PW-1:0]       win_off;
    logic [PW-1:0]       win_sum;
    logic [NREQ_LOG-1:0] win_idx;
    logic [NREQ_LOG-1:0] ptr_next;
    logic                win_valid;
    logic [WIDTH-1:0]    a_mux;
    logic [WIDTH-1:0]    b_mux;

    // Rotate the requests so bit 0 is the lane at ptr; the lowest set bit then wins.
    assign req_dbl = {bus.req, bus.req};
    assign req_rot = req_dbl[{1'b0, ptr} +: NREQ];

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        win_valid = 1'b0;
        win_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_valid = 1'b1;
                win_off   = PW'(k);
            end
        end
    end

    assign win_sum  = {1'b0, ptr} + win_off;
    assign win_idx  = (win_sum >= PW'(NREQ)) ? NREQ_LOG'(win_sum - PW'(NREQ))
                                             : NREQ_LOG'(win_sum);
    assign ptr_next = (gnt_idx == NREQ_LOG'(NREQ - 1)) ? '0 : gnt_idx + NREQ_LOG'(1);

    // gnt is one-hot, so a priority-free select is enough; both buses read 0 while idle.
    always_comb begin
        a_mux = '0;
        b_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                a_mux = bus.req_a[i*WIDTH +: WIDTH];
                b_mux = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            go_q    <= 1'b0;
            rem_q   <= '0;
            quot_q  <= '0;
            error_q <= 1'b0;
        end else begin
            done_q <= '0;
            go_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_valid && bus.div_ready) begin
                        gnt_q   <= NREQ'(1) << win_idx;
                        gnt_idx <= win_idx;
                        go_q    <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    // The divider's outputs already reflect the go, so ready here means finished.
                    if (bus.div_ready) begin
                        rem_q   <= bus.div_rem;
                        quot_q  <= bus.div_quot;
                        error_q <= bus.div_error;
                        done_q  <= gnt_q;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    ptr   <= ptr_next;
                    gnt_q <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.div_go    = go_q;
    assign bus.div_a     = a_mux;
    assign bus.div_b     = b_mux;
    assign bus.res_rem   = rem_q;
    assign bus.res_quot  = quot_q;
    assign bus.res_error = error_q;
endmodule

// File: tb/tb_divmod_arbiter.sv
// Self-checking bench for divmod_arbiter: a 4-lane and a 3-lane instance, each with a
// behavioural multi-cycle divider, directed vectors, hand sequences and a random run.
module tb_divmod_arbiter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    divmod_arbiter_if #(.WIDTH_LOG(4), .NREQ(4)) ifa ();
    divmod_arbiter_if #(.WIDTH_LOG(4), .NREQ(3)) ifb ();

    divmod_arbiter #(.WIDTH_LOG(4), .NREQ(4), .NREQ_LOG(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    divmod_arbiter #(.WIDTH_LOG(4), .NREQ(3), .NREQ_LOG(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int   busy_len     = 3;
    logic foreign_busy = 1'b0;
    int   n_checks     = 0;
    int   n_fail       = 0;

    // Divider model: b==0 completes at once with error (quot all ones, rem=a);
    // otherwise ready drops for busy_len cycles after go.
    logic [W-1:0] dva_q, dva_r, dvb_q, dvb_r;
    logic         dva_rdy, dva_err, dvb_rdy, dvb_err;
    int           dva_cnt, dvb_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dva_rdy <= 1'b1; dva_err <= 1'b0; dva_q <= '0; dva_r <= '0; dva_cnt <= 0;
        end else if (ifa.div_go) begin
            if (ifa.div_b == '0) begin
                dva_rdy <= 1'b1; dva_err <= 1'b1; dva_q <= '1; dva_r <= ifa.div_a;
            end else begin
                dva_rdy <= 1'b0; dva_err <= 1'b0; dva_cnt <= busy_len;
                dva_q <= ifa.div_a / ifa.div_b; dva_r <= ifa.div_a % ifa.div_b;
            end
        end else if (!dva_rdy) begin
            if (dva_cnt <= 1) dva_rdy <= 1'b1;
            else              dva_cnt <= dva_cnt - 1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvb_rdy <= 1'b1; dvb_err <= 1'b0; dvb_q <= '0; dvb_r <= '0; dvb_cnt <= 0;
        end else if (ifb.div_go) begin
            if (ifb.div_b == '0) begin
                dvb_rdy <= 1'b1; dvb_err <= 1'b1; dvb_q <= '1; dvb_r <= ifb.div_a;
            end else begin
                dvb_rdy <= 1'b0; dvb_err <= 1'b0; dvb_cnt <= busy_len;
                dvb_q <= ifb.div_a / ifb.div_b; dvb_r <= ifb.div_a % ifb.div_b;
            end
        end else if (!dvb_rdy) begin
            if (dvb_cnt <= 1) dvb_rdy <= 1'b1;
            else              dvb_cnt <= dvb_cnt - 1;
        end
    end

    assign ifa.div_ready = dva_rdy & ~foreign_busy;
    assign ifa.div_error = dva_err;
    assign ifa.div_rem   = dva_r;
    assign ifa.div_quot  = dva_q;
    assign ifb.div_ready = dvb_rdy;
    assign ifb.div_error = dvb_err;
    assign ifb.div_rem   = dvb_r;
    assign ifb.div_quot  = dvb_q;

    typedef struct {
        int         lane;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic       err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input bit on_b, input int budget, output logic [3:0] dv);
        dv = '0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            dv = on_b ? {1'b0, ifb.done} : ifa.done;
            if (dv != '0) return;
        end
    endtask

    // Issues one request on the 4-lane instance from IDLE; lat counts the request cycle as 1.
    task automatic run_single(input vec_t v, output int lat, output int gos, output int dones,
                              output logic [3:0] dv, output logic [W-1:0] q, output logic [W-1:0] r,
                              output logic e);
        ifa.req_a[v.lane*W +: W] = v.a;
        ifa.req_b[v.lane*W +: W] = v.b;
        ifa.req[v.lane] = 1'b1;
        lat = 1; gos = 0; dones = 0; dv = '0; q = '0; r = '0; e = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            lat++;
            if (ifa.div_go) gos++;
            if (ifa.done != '0) begin
                dones++; dv = ifa.done; q = ifa.res_quot; r = ifa.res_rem; e = ifa.res_error;
                break;
            end
        end
        ifa.req[v.lane] = 1'b0;
        @(negedge clk);
        if (ifa.done != '0) dones++;
        if (ifa.div_go) gos++;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    vec_t         vecs[5];
    logic [3:0]   cexp[4];
    logic [3:0]   wexp[4];
    logic [3:0]   dv;
    logic [W-1:0] q, r;
    logic         e;
    int           lat, gos, dones, cnt;

    // Random-run reference state
    logic [3:0]   pend, req_seen, exp_g;
    logic [W-1:0] ma[4], mb[4];
    int           mptr, cur, ncomp;
    bit           prev_busy;

    initial begin
        vecs[0] = '{lane: 0, a: 16'd100,   b: 16'd7,    quot: 16'd14,    rem: 16'd2,   err: 1'b0};
        vecs[1] = '{lane: 1, a: 16'd50,    b: 16'd0,    quot: 16'hFFFF,  rem: 16'd50,  err: 1'b1};
        vecs[2] = '{lane: 2, a: 16'hFFFF,  b: 16'd1,    quot: 16'hFFFF,  rem: 16'd0,   err: 1'b0};
        vecs[3] = '{lane: 3, a: 16'd1234,  b: 16'd1234, quot: 16'd1,     rem: 16'd0,   err: 1'b0};
        vecs[4] = '{lane: 0, a: 16'd5,     b: 16'd9,    quot: 16'd0,     rem: 16'd5,   err: 1'b0};
        cexp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        wexp = '{4'b0100, 4'b0001, 4'b0010, 4'b0100};

        ifa.req = '0; ifa.req_a = '0; ifa.req_b = '0;
        ifb.req = '0; ifb.req_a = '0; ifb.req_b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", ifa.gnt, 0);
        check("rst_done", ifa.done, 0);
        check("rst_go", ifa.div_go, 0);
        check("rst_quot", ifa.res_quot, 0);
        check("rst_rem", ifa.res_rem, 0);
        check("rst_err", ifa.res_error, 0);
        check("rst_gnt_b", ifb.gnt, 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed single-lane vectors
        busy_len = 3;
        for (int i = 0; i < 5; i++) begin
            run_single(vecs[i], lat, gos, dones, dv, q, r, e);
            check($sformatf("vec%0d_done", i), dv, 4'b0001 << vecs[i].lane);
            check($sformatf("vec%0d_lat", i), lat, (vecs[i].b == '0) ? 4 : 4 + busy_len);
            check($sformatf("vec%0d_go_cycles", i), gos, 1);
            check($sformatf("vec%0d_done_pulses", i), dones, 1);
            check($sformatf("vec%0d_quot", i), q, vecs[i].quot);
            check($sformatf("vec%0d_rem", i), r, vecs[i].rem);
            check($sformatf("vec%0d_err", i), e, vecs[i].err);
        end

        // Contention: lanes 0 and 2 held from reset alternate
        rst = 1'b0;
        ifa.req_a[0 +: W] = 16'd30; ifa.req_b[0 +: W] = 16'd4;
        ifa.req_a[2*W +: W] = 16'd77; ifa.req_b[2*W +: W] = 16'd0;
        ifa.req = 4'b0101;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(1'b0, 60, dv);
            check($sformatf("contend_done%0d", k), dv, cexp[k]);
            if (k == 3) ifa.req = '0;
        end
        @(negedge clk);

        // Wrap fairness on the 3-lane instance: move ptr to 2, then all lanes request
        ifb.req_a = {16'd90, 16'd60, 16'd30};
        ifb.req_b = {16'd9, 16'd0, 16'd7};
        ifb.req = 3'b010;
        wait_done(1'b1, 60, dv);
        check("wrap_setup_done", dv, 4'b0010);
        ifb.req = '0;
        @(negedge clk);
        ifb.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_done(1'b1, 60, dv);
            check($sformatf("wrap_done%0d", k), dv, wexp[k]);
            if (k == 3) ifb.req = '0;
        end
        @(negedge clk);

        // Divider busy from a foreign source: no grant until ready rises
        foreign_busy = 1'b1;
        ifa.req_a[W +: W] = 16'd10; ifa.req_b[W +: W] = 16'd3;
        ifa.req[1] = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.gnt != '0) cnt++;
        end
        check("busy_no_grant", cnt, 0);
        foreign_busy = 1'b0;
        wait_done(1'b0, 60, dv);
        check("busy_done", dv, 4'b0010);
        check("busy_quot", ifa.res_quot, 16'd3);
        check("busy_rem", ifa.res_rem, 16'd1);
        ifa.req[1] = 1'b0;
        @(negedge clk);

        // Request drop: lane 3 lets go during WAIT, lanes 0 and 2 arrive meanwhile
        busy_len = 4;
        ifa.req_a[3*W +: W] = 16'd200; ifa.req_b[3*W +: W] = 16'd9;
        ifa.req = 4'b1000;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ifa.gnt != '0) break;
        end
        check("drop_gnt3", ifa.gnt, 4'b1000);
        @(negedge clk);
        ifa.req[3] = 1'b0;
        ifa.req_a[0 +: W] = 16'd9; ifa.req_b[0 +: W] = 16'd3;
        ifa.req_a[2*W +: W] = 16'd8; ifa.req_b[2*W +: W] = 16'd2;
        ifa.req[0] = 1'b1; ifa.req[2] = 1'b1;
        wait_done(1'b0, 60, dv);
        check("drop_done3", dv, 4'b1000);
        check("drop_quot3", ifa.res_quot, 16'd22);
        check("drop_rem3", ifa.res_rem, 16'd2);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ifa.gnt != '0) break;
        end
        check("drop_next_gnt", ifa.gnt, 4'b0001);
        wait_done(1'b0, 60, dv);
        check("drop_done0", dv, 4'b0001);
        check("drop_quot0", ifa.res_quot, 16'd3);
        ifa.req[0] = 1'b0;
        wait_done(1'b0, 60, dv);
        check("drop_done2", dv, 4'b0100);
        check("drop_quot2", ifa.res_quot, 16'd4);
        ifa.req[2] = 1'b0;
        @(negedge clk);

        // Asynchronous reset while waiting on a long division
        busy_len = 10;
        ifa.req_a[2*W +: W] = 16'hFFFF; ifa.req_b[2*W +: W] = 16'd1;
        ifa.req[2] = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_pre_gnt", ifa.gnt, 4'b0100);
        #2 rst = 1'b0;
        #1;
        check("arst_gnt", ifa.gnt, 0);
        check("arst_done", ifa.done, 0);
        check("arst_go", ifa.div_go, 0);
        check("arst_quot", ifa.res_quot, 0);
        ifa.req = '0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (ifa.done != '0) cnt++;
        end
        rst = 1'b1;
        repeat (14) begin
            @(negedge clk);
            if (ifa.done != '0 || ifa.gnt != '0) cnt++;
        end
        check("arst_no_done", cnt, 0);
        run_single('{lane: 2, a: 16'hFFFF, b: 16'd1, quot: 16'hFFFF, rem: 16'd0, err: 1'b0},
                   lat, gos, dones, dv, q, r, e);
        check("arst_after_done", dv, 4'b0100);
        check("arst_after_quot", q, 16'hFFFF);
        check("arst_after_lat", lat, 4 + busy_len);

        // Random traffic against a round-robin reference model
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mptr = 0; pend = '0; req_seen = '0; prev_busy = 1'b0; cur = -1; ncomp = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (ifa.gnt != '0 && !prev_busy) begin
                cur   = rr_pick(req_seen, mptr);
                exp_g = (cur >= 0) ? (4'b0001 << cur) : 4'b0000;
                check("rand_grant", ifa.gnt, exp_g);
            end
            prev_busy = (ifa.gnt != '0);
            if (ifa.done != '0) begin
                exp_g = (cur >= 0) ? (4'b0001 << cur) : 4'b0000;
                check("rand_done", ifa.done, exp_g);
                if (cur >= 0) begin
                    check("rand_err", ifa.res_error, (mb[cur] == '0));
                    check("rand_quot", ifa.res_quot, (mb[cur] == '0) ? 16'hFFFF : ma[cur] / mb[cur]);
                    check("rand_rem", ifa.res_rem, (mb[cur] == '0) ? ma[cur] : ma[cur] % mb[cur]);
                    mptr = (cur + 1) % 4;
                    pend[cur] = 1'b0;
                    ifa.req[cur] = 1'b0;
                    ncomp++;
                end
            end
            if (cyc < 2500) begin
                for (int l = 0; l < 4; l++) begin
                    if (!pend[l] && $urandom_range(0, 5) == 0) begin
                        ma[l] = 16'($urandom);
                        mb[l] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
                        ifa.req_a[l*W +: W] = ma[l];
                        ifa.req_b[l*W +: W] = mb[l];
                        ifa.req[l] = 1'b1;
                        pend[l] = 1'b1;
                    end
                end
            end
            foreign_busy = (cyc < 2500) && ($urandom_range(0, 9) == 0);
            busy_len     = $urandom_range(1, 6);
            req_seen     = ifa.req;
            if (cyc >= 2500 && pend == '0 && ifa.gnt == '0) break;
        end
        check("rand_drained", pend, 0);
        check("rand_enough_ops", (ncomp > 50), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
